// File: rtl/clock_seq_pkg.sv
// rtl/clock_seq_pkg.sv - shared types and helpers for clock-control sequencers
//
// Purpose : state encoding, limits, a one-hot decode helper and the default
//           settle time shared by the clock-select sequencer and its
//           settle counter.
// Contents: state_t, MAX_CLOCKS, MAX_SEL_W, DEFAULT_SETTLE_CYCLES, onehot()
package clock_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    GATE_ON  = 2'd3
  } state_t;

  localparam int MAX_CLOCKS            = 16;
  localparam int MAX_SEL_W             = 4;
  localparam int DEFAULT_SETTLE_CYCLES = 8;

  // One-hot decode over the widest supported mux; callers keep the low
  // NUM_CLOCKS bits.
  function automatic logic [MAX_CLOCKS-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_CLOCKS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable down-counter with zero flag for settle timing
//
// Purpose : times a phase of a clock-control sequence. load has priority over
//           dec; the count holds at zero rather than wrapping.
// Ports   : clock    in   reference clock
//           reset    in   asynchronous, active-low
//           load     in   load load_val this cycle
//           load_val in   CNT_W value to load
//           dec      in   decrement this cycle
//           zero     out  count is zero
module settle_counter
  import clock_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clock_select_sequencer.sv
// rtl/clock_select_sequencer.sv - glitch-free clock-mux switch sequencer
//
// Purpose : on an accepted request, gates off every source, moves the mux
//           select, ungates the new source, then reports done; each phase
//           lasts SETTLE_CYCLES reference cycles. All outputs are registered.
// Ports   : clock     in   always-on reference clock
//           reset     in   asynchronous, active-low
//           req_valid in   switch request
//           req_ready out  request can be accepted (sequencer idle)
//           req_sel   in   requested source index
//           busy      out  switch sequence in progress
//           done      out  one-cycle pulse: request completed or no-op
//           err       out  one-cycle pulse: request index out of range
//           mux_sel   out  mux select
//           gate_en   out  per-source gater enables (never multi-hot)
//           cur_sel   out  committed source
module clock_select_sequencer
  import clock_seq_pkg::*;
#(
  parameter int NUM_CLOCKS    = 4,
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = 4,
  parameter int RESET_SEL     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_W-1:0]      req_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SEL_W-1:0]      mux_sel,
  output logic [NUM_CLOCKS-1:0] gate_en,
  output logic [SEL_W-1:0]      cur_sel
);

  // One extra bit so NUM_CLOCKS == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]            NUM_CLOCKS_EXT = (SEL_W+1)'(NUM_CLOCKS);
  localparam logic [CNT_W-1:0]          SETTLE_LOAD    = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0]          RESET_SEL_V    = SEL_W'(RESET_SEL);
  localparam logic [MAX_CLOCKS-1:0]     RESET_OH_FULL  = onehot(MAX_SEL_W'(RESET_SEL));
  localparam logic [NUM_CLOCKS-1:0]     RESET_GATE     = RESET_OH_FULL[NUM_CLOCKS-1:0];

  state_t                  state, next_state;
  logic [SEL_W-1:0]        target;
  logic                    cnt_zero, cnt_load, cnt_dec;
  logic                    accept, sel_invalid, sel_same, start;
  logic [NUM_CLOCKS-1:0]   target_oh;

  logic                    req_ready_d, busy_d, done_d, err_d;
  logic [SEL_W-1:0]        mux_sel_d, cur_sel_d;
  logic [NUM_CLOCKS-1:0]   gate_en_d;

  // req_ready is the registered image of state == IDLE.
  assign accept      = req_valid & req_ready;
  assign sel_invalid = ({1'b0, req_sel} >= NUM_CLOCKS_EXT);
  assign sel_same    = (req_sel == cur_sel);
  assign start       = accept & ~sel_invalid & ~sel_same;

  // Every non-IDLE state entry restarts the phase timer; the return to IDLE
  // does not need one.
  assign cnt_load = (next_state != state) && (next_state != IDLE);
  assign cnt_dec  = (state != IDLE);

  settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    target_oh = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      target_oh[i] = (target == SEL_W'(i));
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start)    next_state = GATE_OFF;
      GATE_OFF: if (cnt_zero) next_state = SWITCH;
      SWITCH:   if (cnt_zero) next_state = GATE_ON;
      GATE_ON:  if (cnt_zero) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_ready_d = (next_state == IDLE);
    busy_d      = (next_state != IDLE);
    done_d      = 1'b0;
    err_d       = 1'b0;
    mux_sel_d   = mux_sel;
    gate_en_d   = gate_en;
    cur_sel_d   = cur_sel;
    case (state)
      IDLE: begin
        err_d  = accept & sel_invalid;
        done_d = accept & ~sel_invalid & sel_same;
        if (start) gate_en_d = '0;
      end
      // mux moves only here, while every gater is off
      GATE_OFF: if (cnt_zero) mux_sel_d = target;
      SWITCH:   if (cnt_zero) gate_en_d = target_oh;
      GATE_ON: begin
        if (cnt_zero) begin
          cur_sel_d = target;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target    <= RESET_SEL_V;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mux_sel   <= RESET_SEL_V;
      gate_en   <= RESET_GATE;
      cur_sel   <= RESET_SEL_V;
    end else begin
      if (start) target <= req_sel;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      mux_sel   <= mux_sel_d;
      gate_en   <= gate_en_d;
      cur_sel   <= cur_sel_d;
    end
  end

endmodule
